div_sequencer: RTL and testbench

- Sequential signed 32-bit divider that executes MIPS DIV for the multicycle CPU datapath.
- Sits downstream of the ALU source A/B muxes, taking dividend and divisor from them; its quotient feeds Lo and its remainder feeds Hi.
- It is upstream of the Hi/Lo registers and of the control unit's divide-by-zero exception path.
- Replaces the fixed-latency divide with an explicit start/busy/done handshake, so the control FSM waits on done instead of counting cycles.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_abs_neg.sv | 13 +
 rtl/div_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential MIPS DIV/DIVU unit.
// The optional unsigned mode is controlled by the DIV_UNSIGNED_EN macro
// (used in div_sequencer.sv).
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
// Used both for taking operand magnitudes and for applying result signs.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/div_sequencer.sv
// Sequential restoring divider executing MIPS DIV with a start/busy/done
// handshake. Quotient is presented on div_lo, remainder on div_hi.
// Optional macro DIV_UNSIGNED_EN adds the is_unsigned input (MIPS DIVU).
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] div_hi,
  output logic             divby0flag
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       r_state;
  div_state_e       w_state_next;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div0;

  logic             w_signed;
  logic             w_dvd_neg;
  logic             w_dvsr_neg;
  logic             w_dvsr_zero;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvsr_abs;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_ok;

`ifdef DIV_UNSIGNED_EN
  assign w_signed = ~is_unsigned;
`else
  assign w_signed = 1'b1;
`endif

  assign w_dvd_neg   = w_signed & dividend[WIDTH-1];
  assign w_dvsr_neg  = w_signed & divisor[WIDTH-1];
  assign w_dvsr_zero = (divisor == '0);

  // Magnitude of |-2^(W-1)| stays as the unsigned pattern 100..0.
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
    .i_val (dividend),
    .i_neg (w_dvd_neg),
    .o_val (w_dvd_abs)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvsr (
    .i_val (divisor),
    .i_neg (w_dvsr_neg),
    .o_val (w_dvsr_abs)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_lo (
    .i_val (r_quo),
    .i_neg (r_q_neg),
    .o_val (w_lo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_hi (
    .i_val (r_rem),
    .i_neg (r_r_neg),
    .o_val (w_hi_fix)
  );

  // Restoring step. The shifted remainder can need WIDTH+1 bits when the
  // divisor uses the full unsigned range, so the trial carries one extra
  // bit beyond that to keep its sign meaningful.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_dvsr};
  assign w_trial_ok = ~w_trial[WIDTH+1];

  // State register; reset overrides any start in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    divby0flag   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = w_dvsr_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        divby0flag   = r_div0;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result sign fix-up.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div0 <= w_dvsr_zero;
            if (!w_dvsr_zero) begin
              r_quo   <= w_dvd_abs;
              r_dvsr  <= w_dvsr_abs;
              r_rem   <= '0;
              r_q_neg <= w_dvd_neg ^ w_dvsr_neg;
              r_r_neg <= w_dvd_neg;
              r_cnt   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          r_rem <= w_trial_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_lo <= w_lo_fix;
          r_hi <= w_hi_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_lo = r_lo;
  assign div_hi = r_hi;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, hand-written
// handshake/reset sequences, and randomized operations against an
// arithmetic reference model. Build with DIV_UNSIGNED_EN to cover DIVU.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         is_unsigned;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] div_lo;
  logic [W-1:0] div_hi;
  logic         divby0flag;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_lo;
  logic [W-1:0] m_hi;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          uns;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          div0;
  } vec_t;

  vec_t vecs[$];

  div_sequencer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_lo     (div_lo),
    .div_hi     (div_hi),
    .divby0flag (divby0flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend's sign, as MIPS DIV requires.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit uns);
    longint sa, sb, q, r;
    if (uns) begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One complete operation. Operands are scrambled while busy; an extra
  // start can be injected at a given busy cycle; optionally start is raised
  // in the done cycle to confirm it is dropped.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit uns,
                        input int inject_at, input bit start_at_done,
                        output int lat, output int busy_cycles,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic flag, output bit seen);
    int cnt;
    int bc;
    @(posedge clock); #1;
    dividend    = a;
    divisor     = b;
    is_unsigned = uns;
    start       = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cnt   = 1;
    bc    = busy ? 1 : 0;
    while (!done && cnt < 100) begin
      dividend = $urandom;
      divisor  = $urandom;
      start    = (cnt == inject_at);
      @(posedge clock); #1;
      cnt++;
      if (busy) bc++;
    end
    start       = 1'b0;
    seen        = done;
    flag        = divby0flag;
    lo          = div_lo;
    hi          = div_hi;
    lat         = cnt + 1;
    busy_cycles = bc;
    if (start_at_done) begin
      dividend = 32'd9;
      divisor  = 32'd4;
      start    = 1'b1;
    end
    @(posedge clock); #1;
    start = 1'b0;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    if (start_at_done) begin
      check("start_at_done_ignored", {31'b0, busy}, 32'd0);
    end
  endtask

  // Apply one operation and compare everything against the model.
  task automatic verify(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit uns, input int inject_at, input bit start_at_done);
    int          lat, bc;
    logic [31:0] lo, hi;
    logic        flag;
    bit          seen;
    logic [63:0] r;
    bit          z;
    z = (b == 32'd0);
    if (!z) begin
      r    = ref_div(a, b, uns);
      m_lo = r[31:0];
      m_hi = r[63:32];
    end
    run_op(a, b, uns, inject_at, start_at_done, lat, bc, lo, hi, flag, seen);
    $display("%s: %08h / %08h uns=%0d -> lo=%08h hi=%08h div0=%0d lat=%0d", tag, a, b, uns, lo, hi, flag, lat);
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, lat, z ? 32'd2 : 32'd35);
    check({tag, "_busy_cycles"}, bc, z ? 32'd1 : 32'd34);
    check({tag, "_lo"}, lo, m_lo);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_div0"}, {31'b0, flag}, {31'b0, z});
  endtask

  initial begin
    int          lat, bc;
    logic [31:0] lo, hi;
    logic        flag;
    bit          seen;
    bit          done_seen;
    logic [31:0] a, b;
    bit          u;

    reset       = 1'b1;
    start       = 1'b0;
    is_unsigned = 1'b0;
    dividend    = '0;
    divisor     = '0;
    m_lo        = '0;
    m_hi        = '0;

    // Directed table (expected values written out by hand).
    vecs.push_back('{32'd7,        32'd2,        1'b0, 32'd3,        32'd1,        1'b0});
    vecs.push_back('{32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0,        1'b0});
    vecs.push_back('{32'd100,      32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 32'd2,        1'b0});
    vecs.push_back('{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 32'd2,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0});
    vecs.push_back('{32'd5,        32'd7,        1'b0, 32'd0,        32'd5,        1'b0});
    vecs.push_back('{32'd7,        32'd2,        1'b0, 32'd3,        32'd1,        1'b0});
    vecs.push_back('{32'd5,        32'd0,        1'b0, 32'd3,        32'd1,        1'b1});
`ifdef DIV_UNSIGNED_EN
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        1'b1, 32'h7FFFFFFF, 32'd1,        1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'd9,        32'd0,        1'b1, 32'd0,        32'hFFFFFFFF, 1'b1});
`endif

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_lo", div_lo, 32'd0);
    check("reset_hi", div_hi, 32'd0);
    check("reset_div0", {31'b0, divby0flag}, 32'd0);

    // Start together with reset must lose.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("reset_beats_start", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_after_reset", {31'b0, busy}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].uns, 0, 1'b0, lat, bc, lo, hi, flag, seen);
      $display("vec%0d: %08h / %08h -> lo=%08h hi=%08h div0=%0d lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, lo, hi, flag, lat, bc);
      check($sformatf("vec%0d_done_seen", i), {31'b0, seen}, 32'd1);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_div0", i), {31'b0, flag}, {31'b0, vecs[i].div0});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].div0 ? 32'd2 : 32'd35);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].div0 ? 32'd1 : 32'd34);
      m_lo = vecs[i].lo;
      m_hi = vecs[i].hi;
    end

    // Start re-asserted while busy is ignored; start in the done cycle too.
    verify("start_while_busy", 32'd7, 32'd2, 1'b0, 5, 1'b0);
    verify("start_at_done", 32'd1000, 32'd3, 1'b0, 0, 1'b1);

    // Reset in cycle 10 of CALC abandons the operation and clears results.
    @(posedge clock); #1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    check("midop_busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midop_reset_busy", {31'b0, busy}, 32'd0);
    check("midop_reset_done", {31'b0, done}, 32'd0);
    check("midop_reset_lo", div_lo, 32'd0);
    check("midop_reset_hi", div_hi, 32'd0);
    check("midop_reset_div0", {31'b0, divby0flag}, 32'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) done_seen = 1'b1;
    end
    check("midop_reset_no_done", {31'b0, done_seen}, 32'd0);
    $display("midop_reset: lo=%08h hi=%08h busy=%0d", div_lo, div_hi, busy);
    m_lo = '0;
    m_hi = '0;

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 16)) : -32'($urandom_range(1, 16));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
`ifdef DIV_UNSIGNED_EN
      u = ($urandom_range(0, 1) == 1);
`else
      u = 1'b0;
`endif
      verify($sformatf("rand%0d", n), a, b, u, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
